// File: rtl/rmon_pkg.sv
// Shared types, limits and sizing helper for the RMON counter bank.
package rmon_pkg;

  localparam int unsigned c_rmon_max_cnt_pw = 32;

  typedef struct packed {
    logic [c_rmon_max_cnt_pw-1:0] value;
    logic                         ovf;
  } t_rmon_cnt;

  // Address width needed to index n entries; never less than one bit.
  function automatic int unsigned f_log2_size(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rmon_counter.sv
// One live RMON event counter with a sticky overflow flag.
module rmon_counter #(
  parameter int unsigned g_cnt_pw   = 4,
  parameter int unsigned g_saturate = 0
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                event_i,
  input  logic                clr_i,
  input  logic                snap_clr_i,
  input  logic                rd_clr_i,
  output logic [g_cnt_pw-1:0] value_o,
  output logic                ovf_o
);

  logic [g_cnt_pw-1:0] value_q, value_d;
  logic                ovf_q, ovf_d;

  always_comb begin
    value_d = value_q;
    ovf_d   = ovf_q;
    // Any clear reloads the counter with this cycle's event so it is not lost.
    if (clr_i || snap_clr_i || rd_clr_i) begin
      value_d = g_cnt_pw'(event_i);
      ovf_d   = 1'b0;
    end else if (event_i) begin
      if (&value_q) begin
        ovf_d   = 1'b1;
        value_d = (g_saturate != 0) ? '1 : '0;
      end else begin
        value_d = value_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      value_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      ovf_q   <= ovf_d;
    end
  end

  assign value_o = value_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/wrsw_rmon_bank.sv
// Multi-port RMON counter bank: live counters, optional snapshot shadow bank
// and a registered read port with read-and-clear.
module wrsw_rmon_bank
  import rmon_pkg::*;
#(
  parameter int unsigned g_nports      = 1,
  parameter int unsigned g_cnt_pp      = 64,
  parameter int unsigned g_cnt_pw      = 4,
  parameter int unsigned g_saturate    = 0,
  parameter int unsigned g_with_shadow = 1
) (
  input  logic                                          clk_i,
  input  logic                                          rst_n_i,
  input  logic [g_nports*g_cnt_pp-1:0]                  events_i,
  input  logic                                          clr_i,
  input  logic                                          snapshot_i,
  input  logic                                          snap_clr_i,
  input  logic                                          rd_req_i,
  input  logic [f_log2_size(g_nports*g_cnt_pp)-1:0]     rd_addr_i,
  input  logic                                          rd_shadow_i,
  input  logic                                          rd_clr_i,
  output logic                                          rd_valid_o,
  output logic [g_cnt_pw:0]                             rd_data_o
);

  localparam int unsigned c_n  = g_nports * g_cnt_pp;
  localparam int unsigned c_aw = f_log2_size(c_n);

  logic [g_cnt_pw-1:0] live_val [c_n];
  logic [c_n-1:0]      live_ovf;
  logic [c_n-1:0]      rd_clr_vec;
  logic [g_cnt_pw:0]   shadow_q [c_n];

  logic snap_en;
  logic snap_clr;
  logic use_shadow;

  assign snap_en    = snapshot_i & (g_with_shadow != 0);
  assign snap_clr   = snap_en & snap_clr_i;
  assign use_shadow = rd_shadow_i & (g_with_shadow != 0);

  // rd_clr_i always targets the live counter, whichever bank is being read.
  always_comb begin
    rd_clr_vec = '0;
    for (int unsigned i = 0; i < c_n; i++) begin
      rd_clr_vec[i] = rd_req_i && rd_clr_i && (rd_addr_i == c_aw'(i));
    end
  end

  for (genvar gi = 0; gi < c_n; gi++) begin : g_cnt
    rmon_counter #(
      .g_cnt_pw   (g_cnt_pw),
      .g_saturate (g_saturate)
    ) u_cnt (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .event_i    (events_i[gi]),
      .clr_i      (clr_i),
      .snap_clr_i (snap_clr),
      .rd_clr_i   (rd_clr_vec[gi]),
      .value_o    (live_val[gi]),
      .ovf_o      (live_ovf[gi])
    );
  end

  if (g_with_shadow != 0) begin : g_shadow
    logic [g_cnt_pw:0] shadow_d [c_n];

    always_comb begin
      for (int unsigned i = 0; i < c_n; i++) begin
        shadow_d[i] = snap_en ? {live_ovf[i], live_val[i]} : shadow_q[i];
      end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        for (int unsigned i = 0; i < c_n; i++) shadow_q[i] <= '0;
      end else begin
        for (int unsigned i = 0; i < c_n; i++) shadow_q[i] <= shadow_d[i];
      end
    end
  end else begin : g_no_shadow
    always_comb begin
      for (int unsigned i = 0; i < c_n; i++) shadow_q[i] = '0;
    end
  end

  logic [g_cnt_pw:0] rd_sel;
  logic [g_cnt_pw:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  // Unmatched (out-of-range) addresses fall through to zero.
  always_comb begin
    rd_sel = '0;
    for (int unsigned i = 0; i < c_n; i++) begin
      if (rd_addr_i == c_aw'(i)) begin
        rd_sel = use_shadow ? shadow_q[i] : {live_ovf[i], live_val[i]};
      end
    end
    rd_valid_d = rd_req_i;
    rd_data_d  = rd_req_i ? rd_sel : rd_data_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;

endmodule
